// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch queue entry payload.
package fetch_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 64;
  localparam int unsigned PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries allocated at request time, filled at response
// time, popped from the head; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               alloc,
  input  logic [PC_W-1:0]    alloc_pc,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CW-1:0]      count,
  output logic [CW-1:0]      unfilled
);

  fetch_entry_t    entries [DEPTH];
  logic [AW-1:0]   head_ptr;
  logic [AW-1:0]   tail_ptr;
  logic [AW-1:0]   fill_ptr;
  logic            fill_ok;

  // Stale slots survive a flush, so mask the head whenever the queue is empty.
  assign head    = (count != '0) ? entries[head_ptr] : '0;
  assign fill_ok = fill && (unfilled != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      unfilled <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      if (alloc) begin
        entries[tail_ptr] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
        tail_ptr          <= tail_ptr + AW'(1);
      end
      if (fill_ok) begin
        entries[fill_ptr].instr  <= fill_data;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr                 <= fill_ptr + AW'(1);
      end
      if (pop) head_ptr <= head_ptr + AW'(1);
      count    <= count + CW'(alloc) - CW'(pop);
      unfilled <= unfilled + CW'(alloc) - CW'(fill_ok);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem requests, stale-response dropping, queue.
// Optional macro FETCH_NOP_ON_BUBBLE_EN drives a NOP/PC=0 bubble when idle.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        decode_stall,
  output logic        fetch_valid,
  output logic [31:0] instruction_Fetch,
  output logic [63:0] programCounter_Fetch
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] pc_q;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   q_unfilled;
  fetch_entry_t    head;
  logic            req_fire;
  logic            fill;
  logic            pop;
  logic            unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^branch_target[1:0];

  assign imem_req_valid = reset && !branch_taken && (q_count < CW'(DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && !branch_taken && (drop_cnt == '0);
  assign fetch_valid    = head.filled && !branch_taken;
  assign pop            = fetch_valid && !decode_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (branch_taken) begin
      pc_q <= {branch_target[63:2], 2'b00};
    end else if (req_fire) begin
      pc_q <= pc_q + PC_W'(PC_STEP);
    end
  end

  // Every unfilled slot flushed by a redirect still has a response in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (branch_taken) begin
      drop_cnt <= drop_cnt + q_unfilled - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (branch_taken),
    .alloc     (req_fire),
    .alloc_pc  (pc_q),
    .fill      (fill),
    .fill_data (imem_rsp_data),
    .pop       (pop),
    .head      (head),
    .count     (q_count),
    .unfilled  (q_unfilled)
  );

`ifdef FETCH_NOP_ON_BUBBLE_EN
  assign instruction_Fetch    = fetch_valid ? head.instr : NOP_INSTR;
  assign programCounter_Fetch = fetch_valid ? head.pc : '0;
`else
  logic [INSTR_W-1:0] last_instr_q;
  logic [PC_W-1:0]    last_pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_instr_q <= '0;
      last_pc_q    <= '0;
    end else if (fetch_valid) begin
      last_instr_q <= head.instr;
      last_pc_q    <= head.pc;
    end
  end

  assign instruction_Fetch    = fetch_valid ? head.instr : last_instr_q;
  assign programCounter_Fetch = fetch_valid ? head.pc : last_pc_q;
`endif

  rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> ((drop_cnt != '0) || (q_unfilled != '0)))
    else $error("fetch_stage: response with no outstanding request");

endmodule
